alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Front-end controller for the WIDTH-bit ALU, whose opcode is the 4-bit button vector boton3..boton0.
- Captures operand A, operand B and the opcode from one shared switch bank over three button presses.
- Drives the ALU for a fixed settle window, then registers the result and flags.
- Rejects invalid opcodes and divide/modulo by zero, and holds the result for display.

Parameters:
- WIDTH, 4, operand/result width.
- EXEC_CYCLES, 2, cycles the ALU inputs are held before S is sampled (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sw  in  WIDTH  operand switches
- op_sw  in  4  opcode switches {boton3,boton2,boton1,boton0}
- btn_next  in  1  step button, level, already debounced
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B
- alu_op  out  4  to ALU {boton3..boton0}
- alu_cin  out  1  to ALU Cin, constant 0
- alu_s  in  WIDTH  from ALU S
- alu_cout  in  1  from ALU Cout
- result  out  WIDTH  latched result
- flag_z  out  1  result==0
- flag_n  out  1  result MSB
- flag_c  out  1  latched Cout (ADD/SUB only, else 0)
- err  out  1  operation rejected
- done  out  1  one-cycle pulse, result valid
- state  out  3  current FSM state code

Behaviour:
- Reset: state=IDLE(0). alu_a, alu_b, result and all flags = 0. alu_op=0000, err=0, done=0, btn_q=0.
- Step event: btn_next & ~btn_q, where btn_q is btn_next registered. A held button is exactly one event.
- Opcodes:
  - 0001 ADD
  - 0010 SUB (ALU computes B−A)
  - 0011 MUL
  - 0100 DIV (A/B)
  - 0101 MOD (A%B)
  - 0110 AND
  - 0111 OR
  - 1000 XOR
  - All other codes are invalid.
- FSM:
  - IDLE(0): on event, alu_a←sw; go GET_B.
  - GET_B(1): on event, alu_b←sw; go GET_OP.
  - GET_OP(2): on event, sample op_sw.
    - Invalid code, or (DIV/MOD and alu_b==0) → ERR.
    - Otherwise op_reg←op_sw, cnt←0, go EXEC.
  - EXEC(3): alu_op=op_reg; cnt increments each cycle. When cnt==EXEC_CYCLES−1:
    - result←alu_s.
    - flag_c←alu_cout if op is ADD/SUB, else 0.
    - Go SHOW.
    - Events during EXEC are ignored, not queued.
  - SHOW(4): done=1 on the first SHOW cycle only. Result and flags held. On event → IDLE.
  - ERR(5): err=1, result=0, flags=0. On event → IDLE, err cleared.
- alu_op=0000 in every state except EXEC. alu_a/alu_b always drive the registered operands.
- Latency: op event sampled at cycle t → EXEC during t+1..t+EXEC_CYCLES → result and done valid at t+EXEC_CYCLES+1.
- flag_z and flag_n are derived combinationally from the result register.
- Leaving SHOW or ERR does not clear result. A new EXEC overwrites it.
- rst in any state, including mid-EXEC, returns to IDLE with all reset values next cycle. No partial result is latched.
- Unused state codes 6–7 → IDLE.

Optional Feature:
- Macro ALU_SEQ_ACCUM_EN.
- Defined: an event in SHOW loads alu_a←result and goes to GET_B, allowing chained operations. An event in ERR still goes to IDLE.
- Undefined: SHOW → IDLE as described above.

Test Plan:
- ADD: sw=0011 ev, sw=0110 ev, op=0001 ev → after 3 cycles result=1001, C=0, Z=0, done one cycle; alu_op=0001 for exactly 2 cycles.
- ADD overflow: A=1111, B=0001, op=0001 → result=0000, Z=1, C=1.
- SUB: A=0011, B=1010, op=0010 → result=0111, C=0. Then A=1000, B=0101 → result=1101, N=1, C=1.
- Errors: A=0110, B=0000, op=0100 → ERR, err=1, result=0, alu_op stays 0000. Op=1111 with any operands → ERR. Next event → IDLE, err=0.
- Reset/hold: hold btn_next high for 5 cycles in IDLE → one capture only. rst asserted on second EXEC cycle → state=0 next cycle, result=0, done never pulses.
- ACCUM (macro defined): 0011+0110=1001; event; B=0001, op=0001 → result=1010 without re-entering A.

Source files
------------

// File: rtl/alu_sequencer.sv
// Button-stepped operand/opcode capture and result latch for a WIDTH-bit ALU.
// Define ALU_SEQ_ACCUM_EN so a step in SHOW reuses the result as operand A.
module alu_sequencer #(
  parameter int WIDTH       = 4,
  parameter int EXEC_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic [3:0]       op_sw,
  input  logic             btn_next,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             err,
  output logic             done,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SHOW   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(EXEC_CYCLES - 1);

  state_t        st;
  logic          btn_q;
  logic          ev;
  logic [CW-1:0] cnt;
  logic          res_valid;
  logic          op_ok;
  logic          div_op;
  logic          addsub;

  assign ev      = btn_next & ~btn_q;
  assign state   = st;
  assign alu_cin = 1'b0;
  assign op_ok   = (op_sw >= 4'd1) && (op_sw <= 4'd8);
  assign div_op  = (op_sw == 4'd4) || (op_sw == 4'd5);
  assign addsub  = (alu_op == 4'd1) || (alu_op == 4'd2);

  // Flags read as zero until a result exists and while an error is shown.
  assign flag_z = res_valid & (result == '0);
  assign flag_n = res_valid & result[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      btn_q     <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 4'd0;
      cnt       <= '0;
      result    <= '0;
      flag_c    <= 1'b0;
      res_valid <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
    end else begin
      btn_q <= btn_next;
      done  <= 1'b0;
      case (st)
        IDLE: begin
          if (ev) begin
            alu_a <= sw;
            st    <= GET_B;
          end
        end
        GET_B: begin
          if (ev) begin
            alu_b <= sw;
            st    <= GET_OP;
          end
        end
        GET_OP: begin
          if (ev) begin
            if (!op_ok || (div_op && alu_b == '0)) begin
              err       <= 1'b1;
              result    <= '0;
              flag_c    <= 1'b0;
              res_valid <= 1'b0;
              st        <= ERR;
            end else begin
              alu_op <= op_sw;
              cnt    <= '0;
              st     <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt == LAST) begin
            result    <= alu_s;
            flag_c    <= addsub ? alu_cout : 1'b0;
            res_valid <= 1'b1;
            alu_op    <= 4'd0;
            done      <= 1'b1;
            st        <= SHOW;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SHOW: begin
          if (ev) begin
`ifdef ALU_SEQ_ACCUM_EN
            alu_a <= result;
            st    <= GET_B;
`else
            st    <= IDLE;
`endif
          end
        end
        ERR: begin
          if (ev) begin
            err <= 1'b0;
            st  <= IDLE;
          end
        end
        default: begin
          alu_op <= 4'd0;
          err    <= 1'b0;
          st     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] op_sw;
  logic       btn_next;
  logic [3:0] alu_a, alu_b, alu_op, alu_s, result;
  logic       alu_cin, alu_cout;
  logic       flag_z, flag_n, flag_c, err, done;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(4), .EXEC_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .sw(sw), .op_sw(op_sw),
    .btn_next(btn_next), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_cin(alu_cin), .alu_s(alu_s),
    .alu_cout(alu_cout), .result(result), .flag_z(flag_z),
    .flag_n(flag_n), .flag_c(flag_c), .err(err),
    .done(done), .state(state)
  );

  // Reference ALU; SUB computes B-A with Cout as borrow.
  always_comb begin
    logic [4:0] t;
    t = 5'd0;
    case (alu_op)
      4'd1: t = {1'b0, alu_a} + {1'b0, alu_b};
      4'd2: t = {1'b0, alu_b} - {1'b0, alu_a};
      4'd3: t = {1'b0, alu_a * alu_b};
      4'd4: t = (alu_b != 0) ? {1'b0, alu_a / alu_b} : 5'd0;
      4'd5: t = (alu_b != 0) ? {1'b0, alu_a % alu_b} : 5'd0;
      4'd6: t = {1'b0, alu_a & alu_b};
      4'd7: t = {1'b0, alu_a | alu_b};
      4'd8: t = {1'b0, alu_a ^ alu_b};
      default: t = 5'd0;
    endcase
    alu_s    = t[3:0];
    alu_cout = t[4];
  end

  task automatic do_reset();
    rst = 1'b1;
    btn_next = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input logic [3:0] v);
    @(negedge clk);
    sw = v;
    btn_next = 1'b1;
    @(negedge clk);
    btn_next = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] op);
    press(a);
    press(b);
    op_sw = op;
    press(sw);
  endtask

  task automatic test_reset();
    sw = 4'hF;
    op_sw = 4'h3;
    do_reset();
    checks++;
    if (state !== 3'd0 || alu_a !== 4'd0 || alu_b !== 4'd0) begin
      errors++;
      $display("FAIL reset_regs: state=%0d a=%h b=%h want 0 0 0",
               state, alu_a, alu_b);
    end
    checks++;
    if ({result, flag_z, flag_n, flag_c} !== 7'd0) begin
      errors++;
      $display("FAIL reset_result: res=%h z=%b n=%b c=%b want 0",
               result, flag_z, flag_n, flag_c);
    end
    checks++;
    if ({alu_op, alu_cin, err, done} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctl: op=%h cin=%b err=%b done=%b want 0",
               alu_op, alu_cin, err, done);
    end
  endtask

  task automatic test_add();
    do_reset();
    run_op(4'h3, 4'h6, 4'h1);
    checks++;
    if (state !== 3'd3 || alu_op !== 4'h1 || alu_a !== 4'h3
        || alu_b !== 4'h6) begin
      errors++;
      $display("FAIL add_exec1: st=%0d op=%h a=%h b=%h want 3 1 3 6",
               state, alu_op, alu_a, alu_b);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd3 || alu_op !== 4'h1 || done !== 1'b0) begin
      errors++;
      $display("FAIL add_exec2: st=%0d op=%h done=%b want 3 1 0",
               state, alu_op, done);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd4 || done !== 1'b1 || result !== 4'h9
        || alu_op !== 4'h0) begin
      errors++;
      $display("FAIL add_show: st=%0d done=%b res=%h op=%h want 4 1 9 0",
               state, done, result, alu_op);
    end
    checks++;
    if (flag_c !== 1'b0 || flag_z !== 1'b0 || flag_n !== 1'b1) begin
      errors++;
      $display("FAIL add_flags: c=%b z=%b n=%b want 0 0 1",
               flag_c, flag_z, flag_n);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== 4'h9 || state !== 3'd4) begin
      errors++;
      $display("FAIL add_hold: done=%b res=%h st=%0d want 0 9 4",
               done, result, state);
    end
  endtask

  task automatic test_add_ovf();
    do_reset();
    run_op(4'hF, 4'h1, 4'h1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (result !== 4'h0 || flag_z !== 1'b1 || flag_c !== 1'b1
        || done !== 1'b1) begin
      errors++;
      $display("FAIL add_ovf: res=%h z=%b c=%b done=%b want 0 1 1 1",
               result, flag_z, flag_c, done);
    end
  endtask

  task automatic test_sub();
    do_reset();
    run_op(4'h3, 4'hA, 4'h2);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (result !== 4'h7 || flag_c !== 1'b0 || flag_n !== 1'b0) begin
      errors++;
      $display("FAIL sub_pos: res=%h c=%b n=%b want 7 0 0",
               result, flag_c, flag_n);
    end
    do_reset();
    run_op(4'h8, 4'h5, 4'h2);
    btn_next = 1'b1;
    @(negedge clk);
    btn_next = 1'b0;
    checks++;
    if (state !== 3'd3 || alu_op !== 4'h2) begin
      errors++;
      $display("FAIL sub_exec: st=%0d op=%h want 3 2", state, alu_op);
    end
    @(negedge clk);
    checks++;
    if (result !== 4'hD || flag_n !== 1'b1 || flag_c !== 1'b1
        || state !== 3'd4) begin
      errors++;
      $display("FAIL sub_neg: res=%h n=%b c=%b st=%0d want d 1 1 4",
               result, flag_n, flag_c, state);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL exec_ev_ignored: st=%0d want 4", state);
    end
  endtask

  task automatic test_errors();
    do_reset();
    run_op(4'h1, 4'h1, 4'h1);
    @(negedge clk);
    @(negedge clk);
`ifdef ALU_SEQ_ACCUM_EN
    press(4'h0);
    press(4'h0);
`else
    press(4'h0);
    press(4'h6);
    press(4'h0);
`endif
    op_sw = 4'h4;
    press(sw);
    checks++;
    if (state !== 3'd5 || err !== 1'b1 || result !== 4'h0
        || alu_op !== 4'h0) begin
      errors++;
      $display("FAIL div0: st=%0d err=%b res=%h op=%h want 5 1 0 0",
               state, err, result, alu_op);
    end
    checks++;
    if ({flag_z, flag_n, flag_c, done} !== 4'd0) begin
      errors++;
      $display("FAIL div0_flags: z=%b n=%b c=%b done=%b want 0",
               flag_z, flag_n, flag_c, done);
    end
    @(negedge clk);
    checks++;
    if (alu_op !== 4'h0 || state !== 3'd5) begin
      errors++;
      $display("FAIL err_hold: op=%h st=%0d want 0 5", alu_op, state);
    end
    press(4'h0);
    checks++;
    if (state !== 3'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL err_exit: st=%0d err=%b want 0 0", state, err);
    end
    run_op(4'h7, 4'h2, 4'hF);
    checks++;
    if (state !== 3'd5 || err !== 1'b1) begin
      errors++;
      $display("FAIL bad_op: st=%0d err=%b want 5 1", state, err);
    end
    press(4'h0);
    checks++;
    if (state !== 3'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL bad_op_exit: st=%0d err=%b want 0 0", state, err);
    end
  endtask

  task automatic test_hold();
    do_reset();
    @(negedge clk);
    sw = 4'h5;
    btn_next = 1'b1;
    repeat (5) begin
      @(negedge clk);
      sw = sw + 4'h1;
    end
    btn_next = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd1 || alu_a !== 4'h5 || alu_b !== 4'h0) begin
      errors++;
      $display("FAIL hold_once: st=%0d a=%h b=%h want 1 5 0",
               state, alu_a, alu_b);
    end
  endtask

  task automatic test_rst_exec();
    int pulses;
    do_reset();
    run_op(4'h3, 4'h6, 4'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (state !== 3'd0 || result !== 4'h0 || done !== 1'b0
        || alu_op !== 4'h0) begin
      errors++;
      $display("FAIL rst_exec: st=%0d res=%h done=%b op=%h want 0",
               state, result, done, alu_op);
    end
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses != 0 || state !== 3'd0) begin
      errors++;
      $display("FAIL rst_no_done: pulses=%0d st=%0d want 0 0",
               pulses, state);
    end
  endtask

`ifdef ALU_SEQ_ACCUM_EN
  task automatic test_accum();
    do_reset();
    run_op(4'h3, 4'h6, 4'h1);
    @(negedge clk);
    @(negedge clk);
    press(4'h0);
    checks++;
    if (state !== 3'd1 || alu_a !== 4'h9) begin
      errors++;
      $display("FAIL accum_load: st=%0d a=%h want 1 9", state, alu_a);
    end
    press(4'h1);
    op_sw = 4'h1;
    press(sw);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (result !== 4'hA || done !== 1'b1) begin
      errors++;
      $display("FAIL accum_res: res=%h done=%b want a 1", result, done);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    sw = 4'h0;
    op_sw = 4'h0;
    btn_next = 1'b0;
    test_reset();
    test_add();
    test_add_ovf();
    test_sub();
    test_errors();
    test_hold();
    test_rst_exec();
`ifdef ALU_SEQ_ACCUM_EN
    test_accum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
